// File: rtl/sipo_pkg.sv
// sipo_pkg: shared types and constants for the sipo_rx serial receiver.
// The frame length depends on the optional parity feature, enabled by
// defining SIPO_RX_PARITY_EN.
package sipo_pkg;

    localparam int SIPO_WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } sipo_state_t;

    // Number of strobed bits in one frame: the data bits, plus the trailing
    // even-parity bit when parity is built in.
    function automatic int sipo_frame_bits(input int width);
`ifdef SIPO_RX_PARITY_EN
        return width + 1;
`else
        return width;
`endif
    endfunction

endpackage

// File: rtl/sipo_bit_counter.sv
// sipo_bit_counter: frame bit counter for sipo_rx. Counts sampled bits from 0
// up to LAST, flags the terminal count, and wraps to 0 when the last bit is
// counted. A synchronous clear restarts the frame.
module sipo_bit_counter #(
    parameter int CW   = 4,
    parameter int LAST = 7
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          incr,
    output logic [CW-1:0] count,
    output logic          terminal
);

    assign terminal = (count == CW'(LAST));

    // Count one per sampled bit; clear has priority so a restart always wins.
    // NOTE: sequential state is assigned with <= so every flop samples the
    // pre-edge values and simulation order between blocks cannot matter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (incr) begin
            count <= terminal ? '0 : count + CW'(1);
        end
    end

endmodule

// File: rtl/sipo_rx.sv
// sipo_rx: serial-in / parallel-out receiver. Bits arrive LSB first under a
// bit strobe after a frame-start strobe; the assembled word is held with
// data_valid until the consumer acknowledges it.
// Optional feature: define SIPO_RX_PARITY_EN to append one even-parity bit to
// each frame and report the check result on parity_err.
module sipo_rx
    import sipo_pkg::*;
#(
    parameter int WIDTH = SIPO_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sipo_start,
    input  logic             sipo_enable,
    input  logic             serial_in,
    input  logic             data_ack,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    output logic             busy,
    output logic             overrun,
    output logic             parity_err
);

    localparam int FRAME_BITS = sipo_frame_bits(WIDTH);
    localparam int CW         = $clog2(WIDTH + 1);

    sipo_state_t      state_q;
    sipo_state_t      state_d;
    logic             clear_cnt;
    logic             incr_cnt;
    logic             load_word;
    logic             set_overrun;
    logic [CW-1:0]    bit_cnt;
    logic             cnt_last;
    logic             data_bit;
    logic [WIDTH-1:0] shreg;

    sipo_bit_counter #(
        .CW   (CW),
        .LAST (FRAME_BITS - 1)
    ) u_bit_counter (
        .clk      (clk),
        .reset    (reset),
        .clear    (clear_cnt),
        .incr     (incr_cnt),
        .count    (bit_cnt),
        .terminal (cnt_last)
    );

    // Positions below WIDTH carry data; the one after them is the parity bit.
    assign data_bit   = (bit_cnt < CW'(WIDTH));
    assign busy       = (state_q == SHIFT);
    assign data_valid = (state_q == HOLD);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and datapath control decode.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case statement can leave one unassigned and infer a latch.
        state_d     = state_q;
        clear_cnt   = 1'b0;
        incr_cnt    = 1'b0;
        load_word   = 1'b0;
        set_overrun = 1'b0;
        case (state_q)
            IDLE: begin
                if (sipo_start) begin
                    clear_cnt = 1'b1;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                if (sipo_start) begin
                    // Abort the partial frame and start over.
                    clear_cnt = 1'b1;
                end else if (sipo_enable) begin
                    incr_cnt = 1'b1;
                    if (cnt_last) begin
                        load_word = 1'b1;
                        state_d   = HOLD;
                    end
                end
            end
            HOLD: begin
                if (data_ack) begin
                    if (sipo_start) begin
                        clear_cnt = 1'b1;
                        state_d   = SHIFT;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (sipo_start) begin
                    // Word still unread: flag the lost start, keep the word.
                    set_overrun = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Shift register: serial_in enters the MSB so the first bit ends in bit 0.
    // NOTE: the shift register is reset along with the control state so a
    // word abandoned by reset can never reappear on data_out.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg <= '0;
        end else if (clear_cnt) begin
            shreg <= '0;
        end else if (incr_cnt && data_bit) begin
            shreg <= {serial_in, shreg[WIDTH-1:1]};
        end
    end

    // Output word register, loaded on the edge that samples the last bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out <= '0;
        end else if (load_word) begin
`ifdef SIPO_RX_PARITY_EN
            data_out <= shreg;
`else
            data_out <= {serial_in, shreg[WIDTH-1:1]};
`endif
        end
    end

    // Sticky overrun flag; only reset clears it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overrun <= 1'b0;
        end else if (set_overrun) begin
            overrun <= 1'b1;
        end
    end

`ifdef SIPO_RX_PARITY_EN
    logic par_acc;

    // Running XOR of the data bits of the current frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            par_acc <= 1'b0;
        end else if (clear_cnt) begin
            par_acc <= 1'b0;
        end else if (incr_cnt && data_bit) begin
            par_acc <= par_acc ^ serial_in;
        end
    end

    // Even-parity result captured with the word and held with it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            parity_err <= 1'b0;
        end else if (load_word) begin
            parity_err <= par_acc ^ serial_in;
        end
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_sipo_rx.sv
// tb_sipo_rx: directed self-checking bench for sipo_rx (WIDTH = 8).
// Table-driven frames plus hand-written multi-cycle sequences. Build with
// SIPO_RX_PARITY_EN defined to exercise the parity frame format.
module tb_sipo_rx;

    localparam int WIDTH = 8;

    logic             clk;
    logic             reset;
    logic             sipo_start;
    logic             sipo_enable;
    logic             serial_in;
    logic             data_ack;
    logic [WIDTH-1:0] data_out;
    logic             data_valid;
    logic             busy;
    logic             overrun;
    logic             parity_err;

    int n_checks = 0;
    int n_fail   = 0;

    sipo_rx #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .sipo_start  (sipo_start),
        .sipo_enable (sipo_enable),
        .serial_in   (serial_in),
        .data_ack    (data_ack),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .busy        (busy),
        .overrun     (overrun),
        .parity_err  (parity_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] word;
        bit         gaps;
        bit         ack_in_shift;
        logic [7:0] exp_data;
    } frame_vec_t;

    frame_vec_t vecs[6];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic with_ack);
        sipo_start = 1'b1;
        data_ack   = with_ack;
        tick();
        sipo_start = 1'b0;
        data_ack   = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        sipo_enable = 1'b1;
        serial_in   = b;
        tick();
        sipo_enable = 1'b0;
        serial_in   = 1'b0;
    endtask

    // Data bits LSB first, then the parity bit when parity is built in.
    task automatic send_frame(input logic [7:0] w, input logic pbit, input bit gaps);
        for (int i = 0; i < WIDTH; i++) begin
            if (gaps) tick();
            send_bit(w[i]);
        end
`ifdef SIPO_RX_PARITY_EN
        if (gaps) tick();
        send_bit(pbit);
`endif
    endtask

    // Well-formed frame with correct even parity.
    task automatic send_word(input logic [7:0] w, input bit gaps);
        logic p;
        p = ^w;
        send_frame(w, p, gaps);
    endtask

    task automatic ack_word();
        data_ack = 1'b1;
        tick();
        data_ack = 1'b0;
    endtask

    initial begin
        logic [7:0] tmp;

        vecs[0] = '{word: 8'hA5, gaps: 1'b0, ack_in_shift: 1'b0, exp_data: 8'hA5};
        vecs[1] = '{word: 8'h3C, gaps: 1'b1, ack_in_shift: 1'b0, exp_data: 8'h3C};
        vecs[2] = '{word: 8'h00, gaps: 1'b0, ack_in_shift: 1'b0, exp_data: 8'h00};
        vecs[3] = '{word: 8'hFF, gaps: 1'b1, ack_in_shift: 1'b0, exp_data: 8'hFF};
        vecs[4] = '{word: 8'h80, gaps: 1'b0, ack_in_shift: 1'b1, exp_data: 8'h80};
        vecs[5] = '{word: 8'h01, gaps: 1'b0, ack_in_shift: 1'b0, exp_data: 8'h01};

        reset       = 1'b1;
        sipo_start  = 1'b0;
        sipo_enable = 1'b0;
        serial_in   = 1'b0;
        data_ack    = 1'b0;
        repeat (2) tick();
        check("rst_data_out", 16'(data_out), 16'h00);
        check("rst_valid", 16'(data_valid), 16'h0);
        check("rst_busy", 16'(busy), 16'h0);
        check("rst_overrun", 16'(overrun), 16'h0);
        check("rst_parity_err", 16'(parity_err), 16'h0);
        reset = 1'b0;
        tick();

        // Bit strobes and acks in IDLE do nothing.
        sipo_enable = 1'b1;
        serial_in   = 1'b1;
        data_ack    = 1'b1;
        repeat (3) tick();
        sipo_enable = 1'b0;
        serial_in   = 1'b0;
        data_ack    = 1'b0;
        check("idle_enable_busy", 16'(busy), 16'h0);
        check("idle_enable_valid", 16'(data_valid), 16'h0);

        // Table of complete frames.
        for (int v = 0; v < 6; v++) begin
            pulse_start(1'b0);
            check($sformatf("v%0d_busy_after_start", v), 16'(busy), 16'h1);
            if (vecs[v].ack_in_shift) data_ack = 1'b1;
            send_word(vecs[v].word, vecs[v].gaps);
            data_ack = 1'b0;
            check($sformatf("v%0d_valid", v), 16'(data_valid), 16'h1);
            check($sformatf("v%0d_data", v), 16'(data_out), 16'(vecs[v].exp_data));
            check($sformatf("v%0d_busy_done", v), 16'(busy), 16'h0);
            check($sformatf("v%0d_overrun", v), 16'(overrun), 16'h0);
            check($sformatf("v%0d_parity_err", v), 16'(parity_err), 16'h0);
            // Strobes in HOLD must not disturb the held word.
            sipo_enable = 1'b1;
            serial_in   = ~vecs[v].word[0];
            repeat (2) tick();
            sipo_enable = 1'b0;
            serial_in   = 1'b0;
            check($sformatf("v%0d_hold_data", v), 16'(data_out), 16'(vecs[v].exp_data));
            check($sformatf("v%0d_hold_valid", v), 16'(data_valid), 16'h1);
            ack_word();
            check($sformatf("v%0d_acked_valid", v), 16'(data_valid), 16'h0);
            check($sformatf("v%0d_acked_busy", v), 16'(busy), 16'h0);
        end

        // Abort a partial frame with a new start; no leakage into the next word.
        pulse_start(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        pulse_start(1'b0);
        check("abort_busy", 16'(busy), 16'h1);
        check("abort_valid", 16'(data_valid), 16'h0);
        send_word(8'h0F, 1'b0);
        check("abort_valid_after", 16'(data_valid), 16'h1);
        check("abort_data", 16'(data_out), 16'h0F);
        check("abort_no_overrun", 16'(overrun), 16'h0);
        ack_word();

        // Start while a word is unacknowledged: overrun, word kept.
        pulse_start(1'b0);
        send_word(8'h11, 1'b0);
        check("ovr_valid_11", 16'(data_valid), 16'h1);
        pulse_start(1'b0);
        check("ovr_flag", 16'(overrun), 16'h1);
        check("ovr_data_kept", 16'(data_out), 16'h11);
        check("ovr_valid_kept", 16'(data_valid), 16'h1);
        check("ovr_not_busy", 16'(busy), 16'h0);
        ack_word();
        check("ovr_acked_valid", 16'(data_valid), 16'h0);
        pulse_start(1'b0);
        send_word(8'h22, 1'b0);
        check("ovr_next_data", 16'(data_out), 16'h22);
        check("ovr_next_valid", 16'(data_valid), 16'h1);
        check("ovr_sticky", 16'(overrun), 16'h1);

        // Ack and start together in HOLD go straight to SHIFT.
        pulse_start(1'b1);
        check("ackstart_busy", 16'(busy), 16'h1);
        check("ackstart_valid", 16'(data_valid), 16'h0);
        send_word(8'h5A, 1'b0);
        check("ackstart_data", 16'(data_out), 16'h5A);
        check("ackstart_valid2", 16'(data_valid), 16'h1);
        ack_word();

        // Reset after 5 bits: asynchronous clear, nothing appears afterwards.
        pulse_start(1'b0);
        tmp = 8'b1011_0110;
        for (int i = 0; i < 5; i++) send_bit(tmp[i]);
        reset = 1'b1;
        #1;
        check("midrst_data", 16'(data_out), 16'h00);
        check("midrst_valid", 16'(data_valid), 16'h0);
        check("midrst_busy", 16'(busy), 16'h0);
        check("midrst_overrun", 16'(overrun), 16'h0);
        check("midrst_parity_err", 16'(parity_err), 16'h0);
        tick();
        reset = 1'b0;
        begin
            int bad_valid;
            int bad_busy;
            bad_valid = 0;
            bad_busy  = 0;
            for (int c = 0; c < 12; c++) begin
                sipo_enable = 1'b1;
                serial_in   = 1'($urandom_range(0, 1));
                tick();
                if (data_valid) bad_valid++;
                if (busy) bad_busy++;
            end
            sipo_enable = 1'b0;
            check("postrst_no_valid", 16'(bad_valid), 16'h0);
            check("postrst_no_busy", 16'(bad_busy), 16'h0);
        end
        check("postrst_data", 16'(data_out), 16'h00);

        // Reset while holding a word discards it.
        pulse_start(1'b0);
        send_word(8'hC3, 1'b0);
        check("holdrst_pre_data", 16'(data_out), 16'hC3);
        reset = 1'b1;
        #1;
        check("holdrst_data", 16'(data_out), 16'h00);
        check("holdrst_valid", 16'(data_valid), 16'h0);
        tick();
        reset = 1'b0;
        repeat (3) tick();
        check("holdrst_valid_after", 16'(data_valid), 16'h0);

`ifdef SIPO_RX_PARITY_EN
        // 0x07 has odd weight: parity bit 0 is wrong, parity bit 1 is right.
        pulse_start(1'b0);
        send_frame(8'h07, 1'b0, 1'b0);
        check("par_bad_valid", 16'(data_valid), 16'h1);
        check("par_bad_data", 16'(data_out), 16'h07);
        check("par_bad_err", 16'(parity_err), 16'h1);
        tick();
        check("par_bad_err_held", 16'(parity_err), 16'h1);
        ack_word();
        pulse_start(1'b0);
        send_frame(8'h07, 1'b1, 1'b1);
        check("par_good_data", 16'(data_out), 16'h07);
        check("par_good_err", 16'(parity_err), 16'h0);
        ack_word();
`else
        // Without parity the frame ends after exactly WIDTH bits.
        pulse_start(1'b0);
        for (int i = 0; i < WIDTH - 1; i++) send_bit(1'b1);
        check("nopar_not_early", 16'(data_valid), 16'h0);
        send_bit(1'b0);
        check("nopar_valid", 16'(data_valid), 16'h1);
        check("nopar_data", 16'(data_out), 16'h7F);
        check("nopar_parity_tied", 16'(parity_err), 16'h0);
        ack_word();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
